// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg : shared types, defaults and helpers for shared_bus_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DEFAULT_DW      = 8;
    localparam int DEFAULT_TIMEOUT = 15;
    localparam int MAX_NREQ        = 8;
    localparam int IDX_W           = 3;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker : rotating-priority search, first set req bit starting at ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   winner
);

    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Wrap ptr+i back into 0..NREQ-1 without relying on power-of-two NREQ
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// shared_bus_arbiter : round-robin arbiter of NREQ requesters onto one bus to B
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shared_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clkA1,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    ready,
    input  logic [NREQ*DW-1:0] data_in,
    input  logic               acceptedB,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      sharedBus,
    output logic               validB,
    output logic               busy,
    output logic               timeout_err
);

    localparam int         IW       = $clog2(NREQ);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [7:0]    cnt;

    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic [DW-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = data_in[i*DW +: DW];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clkA1 or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            gnt         <= '0;
            sharedBus   <= '0;
            validB      <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= '0;
            gidx        <= '0;
            cnt         <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= NREQ'(onehot(IDX_W'(pick_idx)));
                        gidx  <= pick_idx;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Data beats withdrawal, withdrawal beats timeout
                    if (ready[gidx]) begin
                        sharedBus <= data_arr[gidx];
                        validB    <= 1'b1;
                        state     <= XFER;
                    end else if (!req[gidx]) begin
                        gnt   <= '0;
                        state <= RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        gnt         <= '0;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                XFER: begin
                    if (acceptedB) begin
                        validB <= 1'b0;
                        gnt    <= '0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    ptr   <= (gidx == LAST_IDX) ? '0 : gidx + IW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Arbitrates one 8-bit shared bus between NREQ requesting devices of the DevA type (req/gnt/ready style) and forwards each granted word to consumer device B.
- Handshake with B: valid/accepted.
- Round-robin fairness, one transfer per grant, and a grant timeout so a stalled requester cannot hold the bus.
- Sits between the requester devices and device B; it is the only driver of sharedBus.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 8, shared bus data width.
- TIMEOUT, 15, max cycles in GRANT waiting for ready before the grant is revoked (1..255).

Ports:
- clkA1  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester bus request, level.
- ready  input  NREQ  per-requester "data valid on data_in" while granted.
- data_in  input  NREQ*DW  requester data; slice i = data_in[i*DW +: DW].
- acceptedB  input  1  B has taken the word on sharedBus.
- gnt  output  NREQ  one-hot grant, registered.
- sharedBus  output  DW  registered bus data to B.
- validB  output  1  sharedBus holds a word for B.
- busy  output  1  state != IDLE.
- timeout_err  output  1  one-cycle pulse on grant revocation by timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gnt=0, sharedBus=0, validB=0, timeout_err=0.
  - ptr=0, timeout counter=0.
  - Applies immediately, including mid-transfer.
- IDLE:
  - If any req bit is set, pick the winner: first set bit searching ptr, ptr+1, …, NREQ-1, 0, … (wrap-around).
  - Next edge: gnt=onehot(winner), state→GRANT, cnt=0.
  - No req: stay in IDLE.
- GRANT (g = granted index):
  - ready[g]=1: capture data_in slice g into sharedBus; validB=1 next cycle; state→XFER.
  - Else if req[g]=0 (requester withdrew): gnt=0, state→RELEASE, no word sent.
  - Else if cnt==TIMEOUT-1: gnt=0, timeout_err=1 for one cycle, state→RELEASE.
  - Else cnt++.
  - acceptedB is ignored in GRANT.
- XFER:
  - validB and gnt held; sharedBus stable.
  - acceptedB=1 sampled: validB=0, gnt=0, state→RELEASE.
  - No timeout on B.
- RELEASE:
  - One turnaround cycle: ptr=(g+1) mod NREQ, state→IDLE.
  - ptr advances on every exit path (transfer, withdrawal, timeout).
- Latency, uncontended, all inputs asserted as early as possible:
  - req high at edge 0 → gnt at edge 1.
  - ready at edge 2 → validB and data at edge 3.
  - acceptedB at edge 4 → gnt/validB low.
  - Next grant no earlier than edge 6.
- sharedBus holds the last captured word until the next capture; it never changes while validB=1.
- Simultaneous requests are resolved purely by ptr; a request arriving mid-transfer waits.
- gnt is always one-hot or zero; never more than one bit set.
- ready to a non-granted index is ignored.

Decomposition:
- Package bus_arb_pkg:
  - state enum {IDLE, GRANT, XFER, RELEASE} (2 bits).
  - Default constants for DW and TIMEOUT.
  - Function onehot(idx).
- Sub-module rr_picker: combinational rotate-priority search.
  - Inputs: req, ptr.
  - Outputs: any, winner index.
  - Instantiated once.

Test Plan:
- Reset mid-XFER: rst low with validB=1 → gnt=0, validB=0, sharedBus=0 within the same cycle; after release, IDLE.
- Single requester: req=01, ready[0]=1, data_in[7:0]=8'hA5, acceptedB 1 cycle after validB → gnt=01 at edge 1; sharedBus=A5 and validB at edge 3; gnt=00 at edge 4.
- Contention: req=11 held, both ready and data 8'h11/8'h22, acceptedB immediate → grants alternate 01,10,01 and sharedBus sequence 11,22,11.
- Timeout: req[1]=1, ready[1]=0 forever, TIMEOUT=15 → gnt=10 for exactly 15 cycles; timeout_err pulses once; gnt cleared; ptr moves to 0; no validB.
- Withdrawal: req[0] dropped in GRANT → gnt=0 next edge, validB never asserted, sharedBus unchanged.
- B backpressure: acceptedB held low 10 cycles in XFER → validB, gnt and sharedBus stable all 10 cycles; ready toggling ignored.
